// File: rtl/snoop_bus_if.sv
// Bus-side signal bundle of the snooping bus arbiter.
// master = arbiter view, slave = cache/memory view.
interface snoop_bus_if #(
  parameter int unsigned ADDR_W = 5,
  parameter int unsigned DATA_W = 7
);
  logic [3:0]          req;
  logic [7:0]          req_msg;
  logic [4*ADDR_W-1:0] req_addr;
  logic [3:0]          grant;
  logic                bus_valid;
  logic [1:0]          bus_owner;
  logic [1:0]          bus_msg;
  logic [ADDR_W-1:0]   bus_addr;
  logic [3:0]          snoop_hit;
  logic [3:0]          snoop_wb;
  logic [4*DATA_W-1:0] snoop_data;
  logic                mem_req;
  logic                mem_we;
  logic [ADDR_W-1:0]   mem_addr;
  logic [DATA_W-1:0]   mem_wdata;
  logic                mem_ready;
  logic [DATA_W-1:0]   mem_rdata;
  logic                resp_valid;
  logic [DATA_W-1:0]   resp_data;
  logic                resp_src;
  logic                busy;

  modport master (
    input  req, req_msg, req_addr, snoop_hit, snoop_wb, snoop_data, mem_ready, mem_rdata,
    output grant, bus_valid, bus_owner, bus_msg, bus_addr, mem_req, mem_we, mem_addr,
           mem_wdata, resp_valid, resp_data, resp_src, busy
  );

  modport slave (
    output req, req_msg, req_addr, snoop_hit, snoop_wb, snoop_data, mem_ready, mem_rdata,
    input  grant, bus_valid, bus_owner, bus_msg, bus_addr, mem_req, mem_we, mem_addr,
           mem_wdata, resp_valid, resp_data, resp_src, busy
  );
endinterface

// File: rtl/snoop_bus_arbiter.sv
// Round-robin shared-bus controller for a four-cache MSI snooping system:
// broadcast, snoop collection, and sequencing of cache supply / write-back / memory fill.
module snoop_bus_arbiter #(
  parameter int unsigned SNOOP_CYCLES = 1,
  parameter int unsigned ADDR_W       = 5,
  parameter int unsigned DATA_W       = 7
) (
  input  logic        clock,
  input  logic        reset,
  snoop_bus_if.master bus
);

  localparam int unsigned CNT_W = 3;

  typedef enum logic [2:0] {
    S_IDLE, S_BCAST, S_SNOOP, S_WB, S_MEM, S_RESP
  } state_e;

  state_e              state_q, state_d;
  logic [1:0]          rr_ptr_q, rr_ptr_d;
  logic [1:0]          owner_q, owner_d;
  logic [3:0]          grant_q, grant_d;
  logic                bus_valid_q, bus_valid_d;
  logic [1:0]          bus_msg_q, bus_msg_d;
  logic [ADDR_W-1:0]   bus_addr_q, bus_addr_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic                mem_req_q, mem_req_d;
  logic                mem_we_q, mem_we_d;
  logic [ADDR_W-1:0]   mem_addr_q, mem_addr_d;
  logic [DATA_W-1:0]   mem_wdata_q, mem_wdata_d;
  logic                resp_valid_q, resp_valid_d;
  logic [DATA_W-1:0]   resp_data_q, resp_data_d;
  logic                resp_src_q, resp_src_d;
  logic                busy_q, busy_d;

  logic [3:0]          elig;
  logic                arb_found;
  logic [1:0]          arb_idx;
  logic [3:0]          hit_m, wb_m;
  logic [1:0]          hit_sel, wb_sel;
  logic [DATA_W-1:0]   hit_data, wb_data;

  // Eligible = requesting with a real message.
  always_comb begin
    for (int i = 0; i < 4; i++) begin
      elig[i] = bus.req[i] && (bus.req_msg[2*i +: 2] != 2'b00);
    end
  end

  // First eligible cache at or above rr_ptr, wrapping 3 -> 0.
  always_comb begin
    arb_found = 1'b0;
    arb_idx   = rr_ptr_q;
    for (int k = 0; k < 4; k++) begin
      if (!arb_found && elig[rr_ptr_q + 2'(k)]) begin
        arb_found = 1'b1;
        arb_idx   = rr_ptr_q + 2'(k);
      end
    end
  end

  // Owner's own snoop response is never a data source; lowest index wins.
  always_comb begin
    hit_m   = bus.snoop_hit & ~grant_q;
    wb_m    = bus.snoop_wb & ~grant_q;
    hit_sel = 2'd0;
    wb_sel  = 2'd0;
    for (int i = 3; i >= 0; i--) begin
      if (hit_m[i]) hit_sel = 2'(i);
      if (wb_m[i])  wb_sel  = 2'(i);
    end
    hit_data = bus.snoop_data[32'(hit_sel)*DATA_W +: DATA_W];
    wb_data  = bus.snoop_data[32'(wb_sel)*DATA_W +: DATA_W];
  end

  always_comb begin
    state_d      = state_q;
    rr_ptr_d     = rr_ptr_q;
    owner_d      = owner_q;
    grant_d      = grant_q;
    bus_valid_d  = 1'b0;
    bus_msg_d    = bus_msg_q;
    bus_addr_d   = bus_addr_q;
    cnt_d        = cnt_q;
    mem_req_d    = mem_req_q;
    mem_we_d     = mem_we_q;
    mem_addr_d   = mem_addr_q;
    mem_wdata_d  = mem_wdata_q;
    resp_valid_d = 1'b0;
    resp_data_d  = resp_data_q;
    resp_src_d   = resp_src_q;

    unique case (state_q)
      S_IDLE: begin
        if (arb_found) begin
          owner_d     = arb_idx;
          grant_d     = 4'b0001 << arb_idx;
          bus_msg_d   = bus.req_msg[2*arb_idx +: 2];
          bus_addr_d  = bus.req_addr[32'(arb_idx)*ADDR_W +: ADDR_W];
          bus_valid_d = 1'b1;
          state_d     = S_BCAST;
        end
      end
      S_BCAST: begin
        cnt_d   = CNT_W'(SNOOP_CYCLES - 1);
        state_d = S_SNOOP;
      end
      S_SNOOP: begin
        if (cnt_q != '0) begin
          cnt_d = cnt_q - CNT_W'(1);
        end else if (bus_msg_q == 2'b11) begin
          // Invalidate comes from S, so no snooper can hold dirty data.
          resp_data_d  = '0;
          resp_src_d   = 1'b1;
          resp_valid_d = 1'b1;
          state_d      = S_RESP;
        end else if (|wb_m) begin
          mem_req_d   = 1'b1;
          mem_we_d    = 1'b1;
          mem_addr_d  = bus_addr_q;
          mem_wdata_d = wb_data;
          state_d     = S_WB;
        end else if (|hit_m) begin
          resp_data_d  = hit_data;
          resp_src_d   = 1'b1;
          resp_valid_d = 1'b1;
          state_d      = S_RESP;
        end else begin
          mem_req_d  = 1'b1;
          mem_we_d   = 1'b0;
          mem_addr_d = bus_addr_q;
          state_d    = S_MEM;
        end
      end
      S_WB: begin
        if (bus.mem_ready) begin
          mem_req_d    = 1'b0;
          resp_data_d  = mem_wdata_q;
          resp_src_d   = 1'b1;
          resp_valid_d = 1'b1;
          state_d      = S_RESP;
        end
      end
      S_MEM: begin
        if (bus.mem_ready) begin
          mem_req_d    = 1'b0;
          resp_data_d  = bus.mem_rdata;
          resp_src_d   = 1'b0;
          resp_valid_d = 1'b1;
          state_d      = S_RESP;
        end
      end
      S_RESP: begin
        rr_ptr_d = owner_q + 2'd1;
        grant_d  = 4'b0000;
        state_d  = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    busy_d = (state_d != S_IDLE);
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q      <= S_IDLE;
      rr_ptr_q     <= '0;
      owner_q      <= '0;
      grant_q      <= '0;
      bus_valid_q  <= 1'b0;
      bus_msg_q    <= '0;
      bus_addr_q   <= '0;
      cnt_q        <= '0;
      mem_req_q    <= 1'b0;
      mem_we_q     <= 1'b0;
      mem_addr_q   <= '0;
      mem_wdata_q  <= '0;
      resp_valid_q <= 1'b0;
      resp_data_q  <= '0;
      resp_src_q   <= 1'b0;
      busy_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      rr_ptr_q     <= rr_ptr_d;
      owner_q      <= owner_d;
      grant_q      <= grant_d;
      bus_valid_q  <= bus_valid_d;
      bus_msg_q    <= bus_msg_d;
      bus_addr_q   <= bus_addr_d;
      cnt_q        <= cnt_d;
      mem_req_q    <= mem_req_d;
      mem_we_q     <= mem_we_d;
      mem_addr_q   <= mem_addr_d;
      mem_wdata_q  <= mem_wdata_d;
      resp_valid_q <= resp_valid_d;
      resp_data_q  <= resp_data_d;
      resp_src_q   <= resp_src_d;
      busy_q       <= busy_d;
    end
  end

  assign bus.grant      = grant_q;
  assign bus.bus_valid  = bus_valid_q;
  assign bus.bus_owner  = owner_q;
  assign bus.bus_msg    = bus_msg_q;
  assign bus.bus_addr   = bus_addr_q;
  assign bus.mem_req    = mem_req_q;
  assign bus.mem_we     = mem_we_q;
  assign bus.mem_addr   = mem_addr_q;
  assign bus.mem_wdata  = mem_wdata_q;
  assign bus.resp_valid = resp_valid_q;
  assign bus.resp_data  = resp_data_q;
  assign bus.resp_src   = resp_src_q;
  assign bus.busy       = busy_q;

endmodule

// File: doc/snoop_bus_arbiter.md
# snoop_bus_arbiter

Shared-bus controller for the four-cache MSI snooping system. It arbitrates bus requests from the per-processor caches round-robin and broadcasts the winner's bus message and tag to all caches. It then collects snoop results and sequences the data source: cache-to-cache supply, snooper write-back, or a main-memory read. The block owns the single memory port, so cache write-backs and miss fills never collide.

## Interface
Parameters:
- SNOOP_CYCLES, 1, length of the snoop window in cycles (legal 1..7)
- ADDR_W, 5, block tag width
- DATA_W, 7, block data width

Ports:
- clock  in  1  system clock, rising edge
- reset  in  1  asynchronous, active-low reset
- req  in  4  per-cache bus request; bit i belongs to processor i
- req_msg  in  8  2 bits per cache: 00 none, 01 read miss, 10 write miss, 11 invalidate
- req_addr  in  4*ADDR_W  tag per cache
- grant  out  4  one-hot, held for the whole transaction
- bus_valid  out  1  broadcast strobe, high for exactly one cycle
- bus_owner  out  2  index of the granted cache
- bus_msg  out  2  latched message of the owner
- bus_addr  out  ADDR_W  latched tag of the owner
- snoop_hit  in  4  cache i holds the block and can supply it
- snoop_wb  in  4  cache i holds the block in M and must write back
- snoop_data  in  4*DATA_W  per-cache block data
- mem_req  out  1  memory access strobe, held until mem_ready
- mem_we  out  1  1 = write-back, 0 = read
- mem_addr  out  ADDR_W  memory tag
- mem_wdata  out  DATA_W  write-back data
- mem_ready  in  1  memory completes the access this cycle
- mem_rdata  in  DATA_W  read data, valid with mem_ready
- resp_valid  out  1  one-cycle completion pulse to the owner
- resp_data  out  DATA_W  fill data (0 for invalidate)
- resp_src  out  1  0 = memory, 1 = cache
- busy  out  1  high in every state except IDLE

## Operation
- Eligibility: cache i is eligible when req[i]=1 and its req_msg field is not 00.
- Arbitration: round-robin. The search starts at rr_ptr and proceeds upward with wrap-around (3 wraps to 0). rr_ptr resets to 0 and becomes owner+1 mod 4 in RESP.
- IDLE: if any cache is eligible, latch the owner index, bus_msg and bus_addr, assert grant, and go to BCAST. Otherwise stay in IDLE.
- BCAST: drive bus_valid=1, then go to SNOOP with the snoop counter loaded to SNOOP_CYCLES-1.
- SNOOP: count down to 0. On the last cycle, sample snoop_hit and snoop_wb with the owner's bit masked off, then branch:
  - msg=11 (invalidate): go to RESP with resp_data=0 and resp_src=1. Any snoop_wb is ignored because the MSI invalidate only comes from S.
  - any masked snoop_wb: select the lowest-index asserting cache and go to WB.
  - else any masked snoop_hit: capture that cache's snoop_data (lowest index wins), set resp_src=1, and go to RESP.
  - else: go to MEM.
- WB: drive mem_req=1, mem_we=1, mem_addr=bus_addr, mem_wdata=the selected cache's data (latched). On mem_ready, resp_data takes the written data, resp_src=1, and the state goes to RESP.
- MEM: drive mem_req=1, mem_we=0, mem_addr=bus_addr. On mem_ready, capture mem_rdata, set resp_src=0, and go to RESP.
- RESP: resp_valid=1 for one cycle with grant still held. Update rr_ptr, then go to IDLE; grant drops on entering IDLE.
- req and req_msg are sampled only in IDLE. Changes mid-transaction are ignored. The owner must drop req in the cycle after resp_valid; if req is still high, the owner is re-arbitrated normally.
- mem_ready is ignored outside WB and MEM.

## Timing
- Reset (async assert, sync release): state=IDLE and rr_ptr=0. Every output is 0: grant, bus_valid, bus_owner, bus_msg, bus_addr, mem_req, mem_we, mem_addr, mem_wdata, resp_valid, resp_data, resp_src, busy.
- Reset mid-transaction aborts immediately; mem_req drops asynchronously.
- Request seen at edge 0: grant and bus_valid in cycle 1; SNOOP occupies cycles 2..1+SNOOP_CYCLES.
- Cache supply or invalidate: resp_valid in cycle 2+SNOOP_CYCLES.
- Memory path: resp_valid one cycle after the mem_ready cycle. With zero-wait memory, resp_valid is in cycle 3+SNOOP_CYCLES.
- Minimum gap between back-to-back transactions: one IDLE cycle.
- Outputs are registered, and mem_addr/mem_wdata are stable while mem_req=1.

## Test plan
- Simultaneous requests: reset, rr_ptr=0, req=1111 with all read misses, no snoop hits, zero-wait memory. Required grant order 0001, 0010, 0100, 1000, then 0001. With SNOOP_CYCLES=1, resp_valid lands 4 cycles after each grant-entry edge.
- Cache-to-cache supply: cache 2 read-misses tag 8; cache 0 asserts snoop_hit with data 0x2A. Required: resp_data=0x2A, resp_src=1, resp_valid 3 cycles after the request edge, mem_req never asserted.
- Snooper write-back: cache 1 write-misses tag 20; cache 3 asserts snoop_wb with data 0x55; memory has 2 wait cycles. Required: mem_we=1, mem_addr=20, mem_wdata=0x55 for 3 cycles, then resp_valid with resp_data=0x55.
- Owner masking and invalidate: cache 0 sends msg 11 while its own snoop_hit and snoop_wb bits are 1. Required: no mem_req, resp_data=0, resp_valid in cycle 3.
- Memory fill: cache 3 read-misses tag 30 with no hits; mem_ready after 4 cycles with rdata 0x11. Required: resp_src=0, resp_data=0x11, busy high throughout.
- Reset mid-operation: assert reset while in MEM. Required: mem_req and grant go to 0 immediately; after release, a pending req[2] alone is granted first (rr_ptr=0 but only cache 2 is eligible).
